// File: rtl/module_spi_transfer_engine_if.sv
// Register-bank side of the SPI transfer engine: the control register and the data bank ports.
// The engine uses the master modport and the register bank uses the slave modport.
interface module_spi_transfer_engine_if #(
    parameter int unsigned ADDR_W = 5
);
    logic [31:0]       ctrl_i;
    logic              ctrl_wr_o;
    logic [31:0]       ctrl_data_o;
    logic [ADDR_W-1:0] data_addr_o;
    logic [7:0]        data_rd_i;
    logic              data_wr_o;
    logic [7:0]        data_wd_o;

    modport master (
        input  ctrl_i, data_rd_i,
        output ctrl_wr_o, ctrl_data_o, data_addr_o, data_wr_o, data_wd_o
    );

    modport slave (
        output ctrl_i, data_rd_i,
        input  ctrl_wr_o, ctrl_data_o, data_addr_o, data_wr_o, data_wd_o
    );
endinterface

// File: rtl/module_spi_transfer_engine.sv
// SPI master transfer engine (mode 0, MSB first). When the send bit is set it streams
// n_tx_end+1 bytes from the data bank out on MOSI, stores each received byte back into the
// same slot, then clears send through the control write port.
// Optional feature macro: SPI_LOOPBACK_EN (receive path samples mosi_o instead of miso_i).
module module_spi_transfer_engine #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned ADDR_W  = 5
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    module_spi_transfer_engine_if.master    bus_io,
    output logic                            busy_o,
    output logic                            sclk_o,
    output logic                            mosi_o,
    input  logic                            miso_i,
    output logic                            cs_o
);

    localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

    typedef enum logic [2:0] {StIdle, StLoad, StShift, StStore, StDone} state_e;

    state_e          state_q, state_d;
    logic [31:0]     ctrl_q, ctrl_d;
    logic [8:0]      tx_cnt_q, tx_cnt_d;
    logic            load_wait_q, load_wait_d;
    logic [DivW-1:0] div_q, div_d;
    logic [2:0]      bit_q, bit_d;
    logic            sclk_q, sclk_d;
    logic [7:0]      tx_q, tx_d;
    logic [7:0]      rx_q, rx_d;
    logic            rx_bit;

`ifdef SPI_LOOPBACK_EN
    assign rx_bit = tx_q[7];
`else
    assign rx_bit = miso_i;
`endif

    // State register with synchronous reset; reset mid-transfer simply abandons it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            ctrl_q      <= '0;
            tx_cnt_q    <= '0;
            load_wait_q <= 1'b0;
            div_q       <= '0;
            bit_q       <= '0;
            sclk_q      <= 1'b0;
            tx_q        <= '0;
            rx_q        <= '0;
        end else begin
            state_q     <= state_d;
            ctrl_q      <= ctrl_d;
            tx_cnt_q    <= tx_cnt_d;
            load_wait_q <= load_wait_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            sclk_q      <= sclk_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
        end
    end

    // Next-state logic: byte load, SCLK phase timing and shift/sample sequencing.
    always_comb begin
        state_d     = state_q;
        ctrl_d      = ctrl_q;
        tx_cnt_d    = tx_cnt_q;
        load_wait_d = load_wait_q;
        div_d       = div_q;
        bit_d       = bit_q;
        sclk_d      = sclk_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        unique case (state_q)
            StIdle: begin
                if (bus_io.ctrl_i[0]) begin
                    // Latched copy already has send cleared, ready for the final write-back.
                    ctrl_d      = {bus_io.ctrl_i[31:1], 1'b0};
                    tx_cnt_d    = '0;
                    load_wait_d = 1'b0;
                    state_d     = StLoad;
                end
            end
            StLoad: begin
                // First cycle covers the bank read latency after the address changed.
                if (!load_wait_q) begin
                    load_wait_d = 1'b1;
                end else begin
                    if (ctrl_q[2]) begin
                        tx_d = 8'hFF;
                    end else if (ctrl_q[3]) begin
                        tx_d = 8'h00;
                    end else begin
                        tx_d = bus_io.data_rd_i;
                    end
                    div_d   = '0;
                    bit_d   = '0;
                    sclk_d  = 1'b0;
                    state_d = StShift;
                end
            end
            StShift: begin
                if (div_q == DivLast) begin
                    div_d  = '0;
                    sclk_d = ~sclk_q;
                    if (!sclk_q) begin
                        rx_d = {rx_q[6:0], rx_bit};
                    end else begin
                        tx_d  = {tx_q[6:0], 1'b0};
                        bit_d = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            state_d = StStore;
                        end
                    end
                end else begin
                    div_d = div_q + DivW'(1);
                end
            end
            StStore: begin
                if (tx_cnt_q == ctrl_q[12:4]) begin
                    state_d = StDone;
                end else begin
                    tx_cnt_d    = tx_cnt_q + 9'd1;
                    load_wait_d = 1'b0;
                    state_d     = StLoad;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs decoded from registered state.
    always_comb begin
        busy_o             = (state_q != StIdle);
        cs_o               = (state_q == StIdle) ? ~bus_io.ctrl_i[1] : 1'b0;
        sclk_o             = sclk_q;
        mosi_o             = tx_q[7];
        bus_io.data_wr_o   = (state_q == StStore);
        bus_io.data_wd_o   = rx_q;
        bus_io.data_addr_o = tx_cnt_q[ADDR_W-1:0];
        bus_io.ctrl_wr_o   = (state_q == StDone);
        bus_io.ctrl_data_o = ctrl_q;
    end

endmodule

// File: tb/tb_module_spi_transfer_engine.sv
// Directed bench for module_spi_transfer_engine: models the register bank and an SPI slave,
// logs engine activity and compares against hand-computed expectations.
module tb_module_spi_transfer_engine;

    localparam int unsigned CLK_DIV = 3;
    localparam int unsigned ADDR_W  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy, sclk, mosi, miso, cs;

    module_spi_transfer_engine_if #(.ADDR_W(ADDR_W)) bus_if ();

    module_spi_transfer_engine #(.CLK_DIV(CLK_DIV), .ADDR_W(ADDR_W)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus_io (bus_if),
        .busy_o (busy),
        .sclk_o (sclk),
        .mosi_o (mosi),
        .miso_i (miso),
        .cs_o   (cs)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Register bank model: host writes first, engine store wins on collision.
    logic [31:0] ctrl_reg;
    logic [7:0]  bank [0:3];
    logic        hc_we = 1'b0;
    logic [31:0] hc_v = '0;
    logic        hb_we = 1'b0;
    logic [1:0]  hb_a = '0;
    logic [7:0]  hb_v = '0;
    logic [7:0]  rd_q;

    initial ctrl_reg = '0;
    assign bus_if.ctrl_i    = ctrl_reg;
    assign bus_if.data_rd_i = rd_q;

    always @(posedge clk) begin
        if (hc_we) ctrl_reg <= hc_v;
        else if (bus_if.ctrl_wr_o) ctrl_reg <= bus_if.ctrl_data_o;
        if (hb_we) bank[hb_a] <= hb_v;
        if (bus_if.data_wr_o) bank[bus_if.data_addr_o] <= bus_if.data_wd_o;
        rd_q <= bank[bus_if.data_addr_o];
    end

    // SPI slave model: presents slv[] bytes MSB first, advances on SCLK falling edges.
    logic [7:0] slv [0:7];
    logic       slv_clr = 1'b0;
    int         s_idx, s_bit;
    logic [7:0] mosi_sr;

    assign miso = slv[s_idx & 7][3'(7 - s_bit)];

    always @(negedge sclk or posedge slv_clr) begin
        if (slv_clr) begin
            s_idx <= 0;
            s_bit <= 0;
        end else if (s_bit == 7) begin
            s_bit <= 0;
            s_idx <= s_idx + 1;
        end else begin
            s_bit <= s_bit + 1;
        end
    end

    always @(posedge sclk or posedge slv_clr) begin
        if (slv_clr) mosi_sr <= '0;
        else mosi_sr <= {mosi_sr[6:0], mosi};
    end

    // Activity monitor.
    logic        mon_clr = 1'b0;
    int          cyc = 0;
    int          wr_n, ctrl_n, pulses, hi_bad, per_ok, cs_bad, hi_len, last_rise;
    int          ctrl_cyc, fall_cyc;
    logic [31:0] ctrl_last;
    logic [1:0]  wr_addr [0:7];
    logic [7:0]  wr_data [0:7];
    logic        busy_prev, sclk_prev;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        busy_prev <= busy;
        sclk_prev <= sclk;
        if (mon_clr) begin
            wr_n <= 0; ctrl_n <= 0; pulses <= 0; hi_bad <= 0; per_ok <= 0; cs_bad <= 0;
            hi_len <= 0; last_rise <= -1000; ctrl_cyc <= 0; fall_cyc <= 0; ctrl_last <= '0;
        end else begin
            if (bus_if.data_wr_o) begin
                wr_addr[wr_n & 7] <= bus_if.data_addr_o;
                wr_data[wr_n & 7] <= bus_if.data_wd_o;
                wr_n <= wr_n + 1;
            end
            if (bus_if.ctrl_wr_o) begin
                ctrl_n <= ctrl_n + 1;
                ctrl_last <= bus_if.ctrl_data_o;
                ctrl_cyc <= cyc;
            end
            if (busy_prev && !busy) fall_cyc <= cyc;
            if (busy && cs) cs_bad <= cs_bad + 1;
            if (sclk && !sclk_prev) begin
                pulses <= pulses + 1;
                if (cyc - last_rise == 2 * CLK_DIV) per_ok <= per_ok + 1;
                last_rise <= cyc;
            end
            if (sclk) begin
                hi_len <= hi_len + 1;
            end else if (sclk_prev) begin
                if (hi_len != CLK_DIV) hi_bad <= hi_bad + 1;
                hi_len <= 0;
            end
        end
    end

    task automatic host_ctrl(input logic [31:0] v);
        @(negedge clk); hc_we = 1'b1; hc_v = v;
        @(negedge clk); hc_we = 1'b0;
    endtask

    task automatic host_bank(input logic [1:0] a, input logic [7:0] v);
        @(negedge clk); hb_we = 1'b1; hb_a = a; hb_v = v;
        @(negedge clk); hb_we = 1'b0;
    endtask

    task automatic clear_logs();
        @(negedge clk); mon_clr = 1'b1; slv_clr = 1'b1;
        @(negedge clk); mon_clr = 1'b0; slv_clr = 1'b0;
    endtask

    task automatic wait_busy(input logic lvl, input int maxc, input string tag);
        bit to = 1'b1;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (busy == lvl) begin
                to = 1'b0;
                break;
            end
        end
        if (to) check_eq(tag, 32'(busy), 32'(lvl));
    endtask

    task automatic run_xfer(input logic [31:0] ctrlv, input string tag);
        host_ctrl(ctrlv);
        wait_busy(1'b1, 10, {tag, "_busy_rise"});
        wait_busy(1'b0, 4000, {tag, "_busy_fall"});
        repeat (3) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) slv[i] = 8'h00;
        for (int i = 0; i < 4; i++) bank[i] = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        clear_logs();

        // Reset values
        check_eq("rst_cs", 32'(cs), 32'h1);
        check_eq("rst_sclk", 32'(sclk), 32'h0);
        check_eq("rst_mosi", 32'(mosi), 32'h0);
        check_eq("rst_busy", 32'(busy), 32'h0);
        check_eq("rst_ctrl_wr", 32'(bus_if.ctrl_wr_o), 32'h0);
        check_eq("rst_data_wr", 32'(bus_if.data_wr_o), 32'h0);
        check_eq("rst_addr", 32'(bus_if.data_addr_o), 32'h0);
        check_eq("rst_ctrl_data", bus_if.ctrl_data_o, 32'h0);
        check_eq("rst_wd", 32'(bus_if.data_wd_o), 32'h0);

        // Single byte: A5 out, 3C back
        host_bank(2'd0, 8'hA5);
        slv[0] = 8'h3C;
        clear_logs();
        run_xfer(32'h1, "t1");
        check_eq("t1_mosi", 32'(mosi_sr), 32'hA5);
        check_eq("t1_bank0", 32'(bank[0]), 32'h3C);
        check_eq("t1_ctrl_n", 32'(ctrl_n), 32'd1);
        check_eq("t1_ctrl_data", ctrl_last, 32'h0);
        check_eq("t1_pulses", 32'(pulses), 32'd8);
        check_eq("t1_hi_bad", 32'(hi_bad), 32'd0);
        check_eq("t1_period", 32'(per_ok), 32'd7);
        check_eq("t1_wr_n", 32'(wr_n), 32'd1);
        check_eq("t1_wr_addr", 32'(wr_addr[0]), 32'd0);
        check_eq("t1_cs_bad", 32'(cs_bad), 32'd0);
        check_eq("t1_ctrl_reg", ctrl_reg, 32'h0);

        // Three bytes; a mid-transfer ctrl write must be ignored
        host_bank(2'd0, 8'h11);
        host_bank(2'd1, 8'h22);
        host_bank(2'd2, 8'h33);
        slv[0] = 8'h11; slv[1] = 8'h22; slv[2] = 8'h33;
        clear_logs();
        host_ctrl(32'h21);
        wait_busy(1'b1, 10, "t2_busy_rise");
        host_ctrl(32'h1);
        wait_busy(1'b0, 4000, "t2_busy_fall");
        repeat (3) @(negedge clk);
        check_eq("t2_pulses", 32'(pulses), 32'd24);
        check_eq("t2_period", 32'(per_ok), 32'd21);
        check_eq("t2_wr_n", 32'(wr_n), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("t2_addr%0d", i), 32'(wr_addr[i]), 32'(i));
            check_eq($sformatf("t2_data%0d", i), 32'(wr_data[i]), 32'(8'h11 * (i + 1)));
        end
        check_eq("t2_ctrl_data", ctrl_last, 32'h20);
        check_eq("t2_ctrl_n", 32'(ctrl_n), 32'd1);

        // all_1s and all_0s both set: all_1s wins
        host_bank(2'd0, 8'h00);
        slv[0] = 8'h5A;
        clear_logs();
        run_xfer(32'hD, "t3");
        check_eq("t3_mosi", 32'(mosi_sr), 32'hFF);
        check_eq("t3_bank0", 32'(bank[0]), 32'h5A);
        check_eq("t3_ctrl_data", ctrl_last, 32'hC);

        // all_0s alone
        host_bank(2'd0, 8'hFF);
        slv[0] = 8'hC3;
        clear_logs();
        run_xfer(32'h9, "t4");
        check_eq("t4_mosi", 32'(mosi_sr), 32'h00);
        check_eq("t4_bank0", 32'(bank[0]), 32'hC3);

        // Five bytes in a four-deep bank: address wraps, fifth byte sends the first reply
        for (int i = 0; i < 4; i++) host_bank(2'(i), 8'(8'hA0 + i));
        for (int i = 0; i < 5; i++) slv[i] = 8'(8'hB0 + i);
        clear_logs();
        run_xfer(32'h41, "t5");
        check_eq("t5_wr_n", 32'(wr_n), 32'd5);
        for (int i = 0; i < 5; i++) begin
            check_eq($sformatf("t5_addr%0d", i), 32'(wr_addr[i]), 32'(i % 4));
            check_eq($sformatf("t5_data%0d", i), 32'(wr_data[i]), 32'(8'hB0 + i));
        end
        check_eq("t5_mosi_last", 32'(mosi_sr), 32'hB0);
        check_eq("t5_bank0", 32'(bank[0]), 32'hB4);
        check_eq("t5_busy_lag", 32'(fall_cyc - ctrl_cyc), 32'd1);
        check_eq("t5_ctrl_data", ctrl_last, 32'h40);

        // Loopback build stores the transmitted byte; default build stores MISO
        host_bank(2'd0, 8'h96);
        slv[0] = 8'h00;
        clear_logs();
        run_xfer(32'h1, "t6");
`ifdef SPI_LOOPBACK_EN
        check_eq("t6_bank0", 32'(bank[0]), 32'h96);
`else
        check_eq("t6_bank0", 32'(bank[0]), 32'h00);
`endif

        // Reset during SHIFT aborts without writes
        host_bank(2'd0, 8'h77);
        clear_logs();
        host_ctrl(32'h1);
        begin
            bit to = 1'b1;
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                if (pulses >= 2) begin
                    to = 1'b0;
                    break;
                end
            end
            if (to) check_eq("t7_reach_shift", 32'(pulses), 32'd2);
        end
        rst = 1'b1; hc_we = 1'b1; hc_v = 32'h0;
        @(negedge clk);
        rst = 1'b0; hc_we = 1'b0;
        check_eq("t7_cs", 32'(cs), 32'h1);
        check_eq("t7_sclk", 32'(sclk), 32'h0);
        check_eq("t7_busy", 32'(busy), 32'h0);
        repeat (60) @(negedge clk);
        check_eq("t7_wr_n", 32'(wr_n), 32'd0);
        check_eq("t7_ctrl_n", 32'(ctrl_n), 32'd0);
        check_eq("t7_busy_after", 32'(busy), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
